// File: rtl/md_sched.sv
// md_sched: sequences HI/LO instructions between the CPU main FSM and the mult/div unit.
// Define MD_NONBLOCK_EN to ack mult/div at issue and let later HI/LO accesses wait in HOLD.
module md_sched #(
  parameter int TIMEOUT = 31,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] rs_in,
  input  logic [31:0] rt_in,
  output logic        ack,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        timeout_err,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic        md_write,
  output logic        md_hilo,
  output logic [31:0] md_rs,
  output logic [31:0] md_rt,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo
);
  typedef enum logic [2:0] {IDLE, HOLD, ISSUE, ARM, WAIT, DONE} state_t;
  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d, md_op_q, md_op_d;
  logic [31:0]      rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d, ack_q, ack_d, start_q, start_d, write_q, write_d, hilo_q, hilo_d;
  logic             issue_d;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          op_d    = op;
          rs_d    = rs_in;
          rt_d    = rt_in;
          state_d = md_busy ? HOLD : ISSUE;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (!md_busy) state_d = ISSUE;
        else if (cnt_d == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      ISSUE: begin
        if (op_q[2:1] == 2'b10) rd_d = op_q[0] ? md_lo : md_hi;
`ifdef MD_NONBLOCK_EN
        state_d = DONE;
`else
        state_d = op_q[2] ? DONE : ARM;
`endif
      end
`ifndef MD_NONBLOCK_EN
      // a started unit that is not busy one cycle later has broken the handshake
      ARM: begin
        err_d   = err_q | ~md_busy;
        state_d = md_busy ? WAIT : DONE;
      end
`endif
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (!md_busy) state_d = DONE;
        else if (cnt_d == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    issue_d = state_d == ISSUE;
    if (issue_d) cnt_d = '0;
    ack_d   = state_d == DONE;
    start_d = issue_d & ~op_d[2];
    md_op_d = start_d ? {1'b0, op_d[1:0]} : 3'b000;
    write_d = issue_d & op_d[2] & op_d[1];
    hilo_d  = write_d & ~op_d[0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      start_q <= 1'b0;
      md_op_q <= '0;
      write_q <= 1'b0;
      hilo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      md_op_q <= md_op_d;
      write_q <= write_d;
      hilo_q  <= hilo_d;
    end
  end
  assign ack         = ack_q;
  assign rd_data     = rd_q;
  assign stall       = req & ~ack_q;
  assign timeout_err = err_q;
  assign md_start    = start_q;
  assign md_op       = md_op_q;
  assign md_write    = write_q;
  assign md_hilo     = hilo_q;
  assign md_rs       = rs_q;
  assign md_rt       = rt_q;
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed scoreboard bench for md_sched with a behavioural mult/div unit.
module tb_md_sched;
  logic        clk = 1'b0, reset = 1'b1, req = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs_in = '0, rt_in = '0;
  logic        ack, stall, timeout_err, md_start, md_write, md_hilo, md_busy;
  logic [2:0]  md_op;
  logic [31:0] rd_data, md_rs, md_rt, md_hi, md_lo;
  int checks = 0, errors = 0;
  int starts = 0, writes = 0, acks = 0, stall_busy = 0;
  logic [2:0]  last_op = '0;
  logic        last_hilo = 1'b0;
  logic [31:0] last_wrs = '0;
  logic [31:0] sb[$];
  int  lat_cfg = 5;
  bit  stuck = 0, noresp = 0, nb = 0;
  logic        u_busy;
  logic [31:0] u_hi, u_lo;
  int          u_cnt;

  always #5 clk = ~clk;

  md_sched #(.TIMEOUT(31), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .rs_in(rs_in), .rt_in(rt_in),
    .ack(ack), .rd_data(rd_data), .stall(stall), .timeout_err(timeout_err),
    .md_start(md_start), .md_op(md_op), .md_write(md_write), .md_hilo(md_hilo),
    .md_rs(md_rs), .md_rt(md_rt), .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo)
  );

  function automatic logic [63:0] md_calc(input logic [1:0] o, input logic [31:0] a, b);
    logic signed [63:0] sa, sb2;
    sa  = {{32{a[31]}}, a};
    sb2 = {{32{b[31]}}, b};
    case (o)
      2'd0:    return {32'b0, a} * {32'b0, b};
      2'd1:    return sa * sb2;
      2'd2:    return {a % b, a / b};
      default: return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    endcase
  endfunction

  // behavioural unit: results land at start, busy lasts lat_cfg cycles
  always @(posedge clk) begin
    if (reset) begin
      u_busy <= 1'b0; u_cnt <= 0; u_hi <= '0; u_lo <= '0;
    end else if (md_start && !noresp) begin
      u_busy <= 1'b1; u_cnt <= lat_cfg;
      {u_hi, u_lo} <= md_calc(md_op[1:0], md_rs, md_rt);
    end else if (md_write) begin
      if (md_hilo) u_hi <= md_rs; else u_lo <= md_rs;
    end else if (u_busy && !stuck) begin
      u_cnt <= u_cnt - 1;
      if (u_cnt <= 1) u_busy <= 1'b0;
    end
  end
  assign md_busy = u_busy;
  assign md_hi   = u_hi;
  assign md_lo   = u_lo;

  always @(negedge clk) begin
    if (md_start) begin starts++; last_op = md_op; end
    if (md_write) begin writes++; last_hilo = md_hilo; last_wrs = md_rs; end
    if (ack) acks++;
    if (stall && md_busy) stall_busy++;
    if (md_start || md_write) begin
      checks++;
      assert (!(md_start && md_write) && md_busy === 1'b0) else begin
        errors++; $error("FAIL proto start=%b write=%b busy=%b required busy=0 and not both", md_start, md_write, md_busy);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++; $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int exp_lat, input bit chg);
    int n;
    logic [31:0] e;
    n = 0;
    @(negedge clk);
    req = 1'b1; op = o; rs_in = a; rt_in = b;
    do begin
      @(negedge clk); n++;
      if (chg && n == 1) op = o ^ 3'b001;
    end while (!ack && n < 200);
    req = 1'b0;
    chk($sformatf("ack_seen_op%0d", o), 32'(ack), 32'h1);
    if (exp_lat >= 0) chk($sformatf("latency_op%0d", o), n, exp_lat);
    if (o[2:1] == 2'b10) begin
      e = sb.pop_front();
      chk($sformatf("rd_data_op%0d", o), rd_data, e);
    end
  endtask

  task automatic mf(input logic lo_sel, input logic [31:0] exp);
    sb.push_back(exp);
    run({2'b10, lo_sel}, 32'h0, 32'h0, 2, 1'b0);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (md_busy && n < 300) begin @(negedge clk); n++; end
    chk("settle_busy", 32'(md_busy), 32'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({ack, stall, timeout_err, md_start, md_write, md_hilo, md_op}), 32'h0);
    chk({tag, "_rd"}, rd_data, 32'h0);
    chk({tag, "_rs"}, md_rs, 32'h0);
    chk({tag, "_rt"}, md_rt, 32'h0);
  endtask

  initial begin
    int s0, a0, mlat;
`ifdef MD_NONBLOCK_EN
    nb = 1;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_zero("reset");
    mlat = nb ? 2 : lat_cfg + 3;

    s0 = starts;
    run(3'b001, 32'hFFFFFFFF, 32'h2, mlat, 1'b0); settle();
    chk("mult_starts", starts - s0, 1);
    chk("mult_op", 32'(last_op), 32'h1);
    mf(1'b0, 32'hFFFFFFFF); mf(1'b1, 32'hFFFFFFFE);

    run(3'b000, 32'hFFFFFFFF, 32'h2, mlat, 1'b0); settle();
    chk("multu_op", 32'(last_op), 32'h0);
    mf(1'b0, 32'h00000001); mf(1'b1, 32'hFFFFFFFE);

    run(3'b011, 32'hFFFFFFF9, 32'h2, mlat, 1'b0); settle();
    chk("div_op", 32'(last_op), 32'h3);
    mf(1'b1, 32'hFFFFFFFD); mf(1'b0, 32'hFFFFFFFF);

    run(3'b010, 32'hFFFFFFF9, 32'h2, mlat, 1'b0); settle();
    mf(1'b1, 32'h7FFFFFFC); mf(1'b0, 32'h00000001);

    s0 = writes;
    run(3'b110, 32'h12345678, 32'h0, 2, 1'b0);
    chk("mthi_writes", writes - s0, 1);
    chk("mthi_hilo", 32'(last_hilo), 32'h1);
    chk("mthi_rs", last_wrs, 32'h12345678);
    mf(1'b0, 32'h12345678);
    run(3'b111, 32'hCAFEBABE, 32'h0, 2, 1'b0);
    chk("mtlo_hilo", 32'(last_hilo), 32'h0);
    mf(1'b1, 32'hCAFEBABE);

    sb.push_back(32'h12345678);
    run(3'b100, 32'h0, 32'h0, 2, 1'b1);

`ifndef MD_NONBLOCK_EN
    lat_cfg = 20;
    @(negedge clk);
    req = 1'b1; op = 3'b001; rs_in = 32'h7; rt_in = 32'h9;
    repeat (5) @(negedge clk);
    chk("wait_stall", 32'(stall), 32'h1);
    reset = 1'b1; req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_zero("midwait_reset");
    s0 = starts;
    repeat (10) @(negedge clk);
    chk("post_reset_starts", starts - s0, 0);
    lat_cfg = 5;

    stuck = 1;
    chk("to_before", 32'(timeout_err), 32'h0);
    a0 = acks;
    run(3'b001, 32'h3, 32'h4, 34, 1'b0);
    chk("to_at_ack", 32'(timeout_err), 32'h1);
    repeat (10) @(negedge clk);
    chk("to_sticky", 32'(timeout_err), 32'h1);
    chk("to_ack_once", acks - a0, 1);
    stuck = 0; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("to_cleared", 32'(timeout_err), 32'h0);

    noresp = 1;
    run(3'b011, 32'h8, 32'h2, 3, 1'b0);
    chk("arm_fault", 32'(timeout_err), 32'h1);
    noresp = 0; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mf(1'b0, 32'h0);
`else
    lat_cfg = 10;
    run(3'b011, 32'hFFFFFFF9, 32'h2, 2, 1'b0);
    s0 = stall_busy;
    sb.push_back(32'hFFFFFFFD);
    run(3'b101, 32'h0, 32'h0, -1, 1'b0);
    chk("nb_stalled", 32'(stall_busy > s0), 32'h1);
    chk("nb_busy_done", 32'(md_busy), 32'h0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
